// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//
// Two-requester round-robin arbiter in front of the APB_Master internal
// interface. Each requester's one-cycle transfer trigger is latched together
// with its address, write data and direction, then the latched requests are
// issued to the shared master one transaction at a time. Completion goes back
// to the owning requester as a registered one-cycle ready pulse plus read data.
//
// Ports:
//   PCLK, PRESET             clock, asynchronous active-low reset
//   transferN                one-cycle trigger from requester N (N = 0, 1)
//   addrN / wdataN / writeN  request fields, valid with transferN
//   readyN                   one-cycle completion pulse to requester N
//   rdataN                   read data for requester N, held until its next completion
//   busyN                    requester N has a pending or in-flight transaction
//   transfer                 one-cycle trigger to APB_Master
//   addr / wdata / write     request fields to APB_Master, stable until completion
//   ready / rdata            completion and read data from APB_Master

module apb_req_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RESET_PRIO = 0
) (
    input  logic              PCLK,
    input  logic              PRESET,

    input  logic              transfer0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              write0,
    output logic              ready0,
    output logic [DATA_W-1:0] rdata0,
    output logic              busy0,

    input  logic              transfer1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              write1,
    output logic              ready1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy1,

    output logic              transfer,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              write,
    input  logic              ready,
    input  logic [DATA_W-1:0] rdata
);

    localparam logic RrInit = RESET_PRIO[0];

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic grant_q, grant_d;
    logic rr_q;
    logic complete;

    logic pend0_q, pend1_q;

    // Hold registers, indexed by requester number.
    logic [1:0][ADDR_W-1:0] hold_addr_q;
    logic [1:0][DATA_W-1:0] hold_wdata_q;
    logic [1:0]             hold_write_q;

    logic              ready0_q, ready1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    //--------------------------------------------------------------------------
    // FSM next state and master-side outputs
    //--------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        complete = 1'b0;
        transfer = 1'b0;
        addr     = '0;
        wdata    = '0;
        write    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // ready from the master is ignored here: nothing is in flight.
                if (pend0_q || pend1_q) begin
                    state_d = StIssue;
                    if (pend0_q && pend1_q) begin
                        grant_d = rr_q;
                    end else begin
                        grant_d = pend1_q;
                    end
                end
            end

            StIssue: begin
                transfer = 1'b1;
                addr     = hold_addr_q[grant_q];
                wdata    = hold_wdata_q[grant_q];
                write    = hold_write_q[grant_q];
                // A master that answers in the issue cycle completes immediately.
                if (ready) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end else begin
                    state_d  = StWait;
                end
            end

            StWait: begin
                addr  = hold_addr_q[grant_q];
                wdata = hold_wdata_q[grant_q];
                write = hold_write_q[grant_q];
                if (ready) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM state, grant and round-robin pointer
    //--------------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q <= StIdle;
            grant_q <= RrInit;
            rr_q    <= RrInit;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (complete) begin
                rr_q <= ~grant_q;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Request capture. A trigger is accepted only while the requester has
    // nothing pending, so a retrigger during its own completion cycle is lost.
    //--------------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            pend0_q         <= 1'b0;
            hold_addr_q[0]  <= '0;
            hold_wdata_q[0] <= '0;
            hold_write_q[0] <= 1'b0;
        end else if (complete && (grant_q == 1'b0)) begin
            pend0_q <= 1'b0;
        end else if (transfer0 && !pend0_q) begin
            pend0_q         <= 1'b1;
            hold_addr_q[0]  <= addr0;
            hold_wdata_q[0] <= wdata0;
            hold_write_q[0] <= write0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            pend1_q         <= 1'b0;
            hold_addr_q[1]  <= '0;
            hold_wdata_q[1] <= '0;
            hold_write_q[1] <= 1'b0;
        end else if (complete && (grant_q == 1'b1)) begin
            pend1_q <= 1'b0;
        end else if (transfer1 && !pend1_q) begin
            pend1_q         <= 1'b1;
            hold_addr_q[1]  <= addr1;
            hold_wdata_q[1] <= wdata1;
            hold_write_q[1] <= write1;
        end
    end

    //--------------------------------------------------------------------------
    // Completion return. rdata is captured for writes as well; the requester
    // that was not granted keeps its previous rdata.
    //--------------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            ready0_q <= 1'b0;
            ready1_q <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            ready0_q <= complete && (grant_q == 1'b0);
            ready1_q <= complete && (grant_q == 1'b1);
            if (complete && (grant_q == 1'b0)) begin
                rdata0_q <= rdata;
            end
            if (complete && (grant_q == 1'b1)) begin
                rdata1_q <= rdata;
            end
        end
    end

    assign ready0 = ready0_q;
    assign ready1 = ready1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign busy0  = pend0_q;
    assign busy1  = pend1_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
module tb_apb_req_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b0;
    logic          transfer0 = 1'b0, transfer1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          write0 = 1'b0, write1 = 1'b0;
    logic          ready0, ready1, busy0, busy1;
    logic [DW-1:0] rdata0, rdata1;
    logic          transfer, write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready = 1'b0;
    logic [DW-1:0] rdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    apb_req_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RESET_PRIO(0)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer0(transfer0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .write0   (write0),
        .ready0   (ready0),
        .rdata0   (rdata0),
        .busy0    (busy0),
        .transfer1(transfer1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .write1   (write1),
        .ready1   (ready1),
        .rdata1   (rdata1),
        .busy1    (busy1),
        .transfer (transfer),
        .addr     (addr),
        .wdata    (wdata),
        .write    (write),
        .ready    (ready),
        .rdata    (rdata)
    );

    always #5 PCLK = ~PCLK;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic clear_inputs();
        transfer0 = 1'b0;
        transfer1 = 1'b0;
        ready     = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        PRESET = 1'b0;
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({transfer, addr, wdata, write} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_master_side: got %b %h %h %b want 0 0 0 0",
                     transfer, addr, wdata, write);
        end
        n_cmp++;
        if ({ready0, ready1, busy0, busy1, rdata0, rdata1} !== 68'h0) begin
            n_err++;
            $display("FAIL reset_req_side: got r%b%b b%b%b %h %h want all 0",
                     ready0, ready1, busy0, busy1, rdata0, rdata1);
        end
        // ready from the master while idle must be ignored.
        ready = 1'b1;
        rdata = 32'hFFFF_FFFF;
        tick();
        ready = 1'b0;
        tick();
        n_cmp++;
        if ({ready0, ready1, transfer, rdata0, rdata1} !== 67'h0) begin
            n_err++;
            $display("FAIL idle_ready_ignored: got r%b%b t%b %h %h want all 0",
                     ready0, ready1, transfer, rdata0, rdata1);
        end
    endtask

    task automatic test_single_read();
        int r1_seen = 0;
        apply_reset();
        // cycle 0
        transfer0 = 1'b1; addr0 = 32'h1000_0004; write0 = 1'b0; wdata0 = 32'h5555_0000;
        tick(); transfer0 = 1'b0;                               // cycle 1
        n_cmp++;
        if ({busy0, transfer} !== 2'b10) begin
            n_err++;
            $display("FAIL single_c1: got busy0=%b transfer=%b want 1 0", busy0, transfer);
        end
        tick();                                                 // cycle 2
        n_cmp++;
        if ({transfer, addr, write} !== {1'b1, 32'h1000_0004, 1'b0}) begin
            n_err++;
            $display("FAIL single_issue: got t=%b a=%h w=%b want 1 10000004 0",
                     transfer, addr, write);
        end
        for (int c = 3; c <= 5; c++) begin
            tick();
            n_cmp++;
            if (transfer !== 1'b0 || ready0 !== 1'b0) begin
                n_err++;
                $display("FAIL single_wait_c%0d: got transfer=%b ready0=%b want 0 0",
                         c, transfer, ready0);
            end
            if (ready1) r1_seen++;
        end
        ready = 1'b1; rdata = 32'h0000_00A5;                    // cycle 5
        tick(); ready = 1'b0; rdata = 32'h0;                    // cycle 6
        n_cmp++;
        if ({ready0, rdata0, busy0} !== {1'b1, 32'h0000_00A5, 1'b0}) begin
            n_err++;
            $display("FAIL single_done: got ready0=%b rdata0=%h busy0=%b want 1 000000a5 0",
                     ready0, rdata0, busy0);
        end
        if (ready1) r1_seen++;
        tick();                                                 // cycle 7
        if (ready1) r1_seen++;
        n_cmp++;
        if (ready0 !== 1'b0 || rdata0 !== 32'h0000_00A5 || r1_seen != 0) begin
            n_err++;
            $display("FAIL single_after: got ready0=%b rdata0=%h ready1_pulses=%0d want 0 a5 0",
                     ready0, rdata0, r1_seen);
        end
    endtask

    // Both request in the same cycle; requester 1 also retriggers while busy.
    task automatic test_simultaneous_retrigger();
        int r1_pulses = 0;
        apply_reset();
        transfer0 = 1'b1; addr0 = 32'h1000_0000; wdata0 = 32'h0000_00C3; write0 = 1'b1;
        transfer1 = 1'b1; addr1 = 32'h1000_3000; wdata1 = 32'h0000_1234; write1 = 1'b1;
        tick(); clear_inputs();                                 // cycle 1
        n_cmp++;
        if ({busy0, busy1} !== 2'b11) begin
            n_err++;
            $display("FAIL simul_busy: got %b%b want 11", busy0, busy1);
        end
        tick();                                                 // cycle 2
        n_cmp++;
        if ({transfer, addr, wdata, write} !== {1'b1, 32'h1000_0000, 32'h0000_00C3, 1'b1}) begin
            n_err++;
            $display("FAIL simul_first: got t=%b a=%h d=%h w=%b want 1 10000000 000000c3 1",
                     transfer, addr, wdata, write);
        end
        transfer1 = 1'b1; addr1 = 32'h1000_3008; wdata1 = 32'hBAD0_BAD0;
        tick(); transfer1 = 1'b0;                               // cycle 3
        ready = 1'b1; rdata = 32'h0000_0077;
        tick(); ready = 1'b0;                                   // cycle 4
        n_cmp++;
        if ({ready0, ready1, transfer, busy1} !== 4'b1001) begin
            n_err++;
            $display("FAIL simul_r0: got ready0=%b ready1=%b transfer=%b busy1=%b want 1 0 0 1",
                     ready0, ready1, transfer, busy1);
        end
        tick();                                                 // cycle 5
        n_cmp++;
        if ({transfer, addr, wdata} !== {1'b1, 32'h1000_3000, 32'h0000_1234}) begin
            n_err++;
            $display("FAIL simul_second: got t=%b a=%h d=%h want 1 10003000 00001234",
                     transfer, addr, wdata);
        end
        ready = 1'b1; rdata = 32'h0000_0099;
        for (int c = 0; c < 6; c++) begin
            tick();
            ready = 1'b0;
            if (ready1) r1_pulses++;
        end
        n_cmp++;
        if (r1_pulses != 1 || rdata1 !== 32'h0000_0099 || rdata0 !== 32'h0000_0077) begin
            n_err++;
            $display("FAIL retrigger_pulses: got pulses=%0d rdata1=%h rdata0=%h want 1 99 77",
                     r1_pulses, rdata1, rdata0);
        end
        // Pointer must now favour requester 0 again.
        transfer0 = 1'b1; addr0 = 32'h1000_0010;
        transfer1 = 1'b1; addr1 = 32'h1000_3010;
        tick(); clear_inputs();
        tick();
        n_cmp++;
        if ({transfer, addr} !== {1'b1, 32'h1000_0010}) begin
            n_err++;
            $display("FAIL rr_end_at_0: got t=%b a=%h want 1 10000010", transfer, addr);
        end
        ready = 1'b1;
        tick(); ready = 1'b0;
        tick(); tick();
        ready = 1'b1;
        tick(); ready = 1'b0;
        tick();
    endtask

    task automatic test_hold_stability();
        apply_reset();
        transfer0 = 1'b1; addr0 = 32'h1000_2000; wdata0 = 32'hDEAD_BEEF; write0 = 1'b1;
        tick(); transfer0 = 1'b0;
        tick();
        n_cmp++;
        if ({transfer, addr, wdata, write} !== {1'b1, 32'h1000_2000, 32'hDEAD_BEEF, 1'b1}) begin
            n_err++;
            $display("FAIL hold_issue: got t=%b a=%h d=%h w=%b", transfer, addr, wdata, write);
        end
        for (int c = 0; c < 10; c++) begin
            tick();
            n_cmp++;
            if ({transfer, addr, wdata, write, ready0} !==
                {1'b0, 32'h1000_2000, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL hold_wait_%0d: got t=%b a=%h d=%h w=%b r0=%b",
                         c, transfer, addr, wdata, write, ready0);
            end
        end
        ready = 1'b1; rdata = 32'h0000_0001;
        tick(); ready = 1'b0;
        n_cmp++;
        if ({ready0, rdata0, addr} !== {1'b1, 32'h1, 32'h0}) begin
            n_err++;
            $display("FAIL hold_done: got ready0=%b rdata0=%h addr=%h want 1 1 0",
                     ready0, rdata0, addr);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int pulses = 0;
        apply_reset();
        transfer0 = 1'b1; addr0 = 32'h1000_0020; wdata0 = 32'h1111_2222; write0 = 1'b1;
        transfer1 = 1'b1; addr1 = 32'h1000_3020;
        tick(); clear_inputs();
        tick(); tick();                                         // now in WAIT
        PRESET = 1'b0;
        #1;
        n_cmp++;
        if ({transfer, addr, wdata, write, busy0, busy1, ready0, ready1} !== 70'h0) begin
            n_err++;
            $display("FAIL rst_mid_wait: got t=%b a=%h d=%h w=%b b%b%b r%b%b want all 0",
                     transfer, addr, wdata, write, busy0, busy1, ready0, ready1);
        end
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        for (int c = 0; c < 6; c++) begin
            ready = 1'b1;
            tick();
            if (ready0 || ready1 || transfer) pulses++;
        end
        ready = 1'b0;
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL rst_no_ready: got %0d activity cycles want 0", pulses);
        end
        transfer0 = 1'b1; transfer1 = 1'b1;
        addr0 = 32'h1000_0030; addr1 = 32'h1000_3030;
        tick(); clear_inputs();
        tick();
        n_cmp++;
        if ({transfer, addr} !== {1'b1, 32'h1000_0030}) begin
            n_err++;
            $display("FAIL rst_new_issue: got t=%b a=%h want 1 10000030", transfer, addr);
        end
        ready = 1'b1; rdata = 32'h0000_0ABC;
        tick(); ready = 1'b0;
        n_cmp++;
        if ({ready0, rdata0} !== {1'b1, 32'h0000_0ABC}) begin
            n_err++;
            $display("FAIL rst_new_done: got ready0=%b rdata0=%h want 1 abc", ready0, rdata0);
        end
        tick();
        ready = 1'b1;
        tick(); ready = 1'b0;
        tick();
    endtask

    // Random triggers and master latencies against a transaction-level model.
    task automatic test_random();
        bit          m_pend[2];
        logic [31:0] m_addr[2], m_wd[2], m_rd[2];
        bit          m_wr[2], m_rdy[2];
        bit          m_infl, m_issue;
        int          m_g, m_rr, last_g, grants;
        logic [133:0] got, exp;
        bit          t_in[2], comp;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_addr[i] = '0; m_wd[i] = '0; m_wr[i] = 0;
            m_rdy[i] = 0; m_rd[i] = '0;
        end
        m_infl = 0; m_issue = 0; m_g = 0; m_rr = 0; last_g = -1; grants = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            exp = {m_issue,
                   m_infl ? m_addr[m_g] : 32'h0,
                   m_infl ? m_wd[m_g] : 32'h0,
                   m_infl ? m_wr[m_g] : 1'b0,
                   m_pend[1], m_pend[0], m_rdy[1], m_rdy[0], m_rd[1], m_rd[0]};
            got = {transfer, addr, wdata, write, busy1, busy0, ready1, ready0, rdata1, rdata0};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random_cyc%0d: got %h want %h", cyc, got, exp);
            end
            // First phase keeps both requesters continuously pending.
            if (cyc < 300) begin
                t_in[0] = 1; t_in[1] = 1;
            end else begin
                t_in[0] = ($urandom_range(0, 3) == 0);
                t_in[1] = ($urandom_range(0, 3) == 0);
            end
            transfer0 = t_in[0]; addr0 = $urandom; wdata0 = $urandom; write0 = $urandom_range(0, 1);
            transfer1 = t_in[1]; addr1 = $urandom; wdata1 = $urandom; write1 = $urandom_range(0, 1);
            ready = m_infl ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            rdata = $urandom;

            comp = m_infl && ready;
            m_rdy[0] = comp && (m_g == 0);
            m_rdy[1] = comp && (m_g == 1);
            if (comp) m_rd[m_g] = rdata;
            if (comp) begin
                m_infl = 0; m_issue = 0; m_rr = 1 - m_g;
                m_pend[m_g] = 0;
                for (int n = 0; n < 2; n++)
                    if (n != m_g && t_in[n] && !m_pend[n]) begin
                        m_pend[n] = 1;
                        m_addr[n] = (n == 0) ? addr0 : addr1;
                        m_wd[n]   = (n == 0) ? wdata0 : wdata1;
                        m_wr[n]   = (n == 0) ? write0 : write1;
                    end
            end else begin
                if (m_infl) begin
                    m_issue = 0;
                end else if (m_pend[0] || m_pend[1]) begin
                    m_g = (m_pend[0] && m_pend[1]) ? m_rr : (m_pend[1] ? 1 : 0);
                    if (cyc < 300 && last_g == m_g) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL random_fair: got grant %0d twice want alternation", m_g);
                    end
                    last_g = m_g; grants++;
                    m_infl = 1; m_issue = 1;
                end
                for (int n = 0; n < 2; n++)
                    if (t_in[n] && !m_pend[n]) begin
                        m_pend[n] = 1;
                        m_addr[n] = (n == 0) ? addr0 : addr1;
                        m_wd[n]   = (n == 0) ? wdata0 : wdata1;
                        m_wr[n]   = (n == 0) ? write0 : write1;
                    end
            end
            tick();
        end
        clear_inputs();
        n_cmp++;
        if (grants < 20) begin
            n_err++;
            $display("FAIL random_activity: got %0d grants want at least 20", grants);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous_retrigger();
        test_hold_stability();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish want completion");
        $fatal(1, "timeout");
    end

endmodule
